// File: rtl/mul_add_shift_pkg.sv
// Shared types and constants for the add-and-shift multiplier.
// The state type, the default operand width and the width of the iteration counter live here.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mul_state_t;

  localparam int MUL_N_DEFAULT = 4;

  // The counter must hold the value N itself, so its width is ceil(log2(N+1)).
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mul_add_shift_if.sv
// Start/busy/done handshake bundle for the add-and-shift multiplier.
// The requester uses the master modport; the multiplier uses the slave modport.
import mul_pkg::*;

interface mul_if #(
  parameter int N = MUL_N_DEFAULT
);
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] rslt;

  modport master (output start, a, b, input busy, done, rslt);
  modport slave  (input start, a, b, output busy, done, rslt);
endinterface

// File: rtl/mul_add_shift_step.sv
// One add-and-shift iteration: conditionally add the multiplicand into the accumulator,
// then shift {carry, accumulator, multiplier} right by one bit. Purely combinational.
module mul_step #(
  parameter int N = 4
) (
  input  logic [N-1:0] m,
  input  logic [N-1:0] acc,
  input  logic [N-1:0] q,
  output logic [N-1:0] acc_next,
  output logic [N-1:0] q_next
);

  logic [N:0] sum;

  // The carry out of the sum is bit N, so it lands in the accumulator MSB after the shift.
  assign sum      = {1'b0, acc} + (q[0] ? {1'b0, m} : {(N + 1){1'b0}});
  assign acc_next = sum[N:1];
  assign q_next   = {sum[0], q[N-1:1]};

endmodule

// File: rtl/mul_add_shift.sv
// Sequential unsigned N x N -> 2N add-and-shift multiplier with a start/busy/done handshake.
// Optional macro MUL_ZERO_SKIP_EN sends zero operands straight to DONE with a zero product.
import mul_pkg::*;

module mul_add_shift #(
  parameter int N = MUL_N_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  mul_if.slave bus
);

  localparam int CW = count_width(N);

  mul_state_t     state, state_nxt;
  logic [N-1:0]   m_q, acc_q, q_q;
  logic [N-1:0]   acc_nxt, q_nxt;
  logic [CW-1:0]  count;
  logic [2*N-1:0] rslt_q;
  logic           busy_q, done_q;
  logic           zero_op;
  logic           last_step;

  mul_step #(.N(N)) u_step (
    .m        (m_q),
    .acc      (acc_q),
    .q        (q_q),
    .acc_next (acc_nxt),
    .q_next   (q_nxt)
  );

`ifdef MUL_ZERO_SKIP_EN
  assign zero_op = (bus.a == '0) || (bus.b == '0);
`else
  assign zero_op = 1'b0;
`endif

  assign last_step = (count == CW'(1));

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = zero_op ? DONE : RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q    <= '0;
      acc_q  <= '0;
      q_q    <= '0;
      count  <= '0;
      rslt_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            m_q   <= bus.a;
            acc_q <= '0;
            q_q   <= bus.b;
            count <= CW'(N);
            if (zero_op) rslt_q <= '0;
          end
        end
        RUN: begin
          acc_q <= acc_nxt;
          q_q   <= q_nxt;
          count <= count - CW'(1);
          if (last_step) rslt_q <= {acc_nxt, q_nxt};
        end
        default: ;
      endcase
    end
  end

  // Handshake flags are registered from the next state so busy/done align with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_nxt != IDLE);
      done_q <= (state_nxt == DONE);
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.rslt = rslt_q;

endmodule

// File: tb/tb_mul_add_shift.sv
// Directed self-checking bench for mul_add_shift with N=4.
// Latency is counted in clock edges after the edge that accepts start.
import mul_pkg::*;

module tb_mul_add_shift;

  localparam int N = 4;

`ifdef MUL_ZERO_SKIP_EN
  localparam int ZERO_LAT  = 0;
  localparam int ZERO_BUSY = 1;
`else
  localparam int ZERO_LAT  = N;
  localparam int ZERO_BUSY = N + 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mul_if #(.N(N)) mif ();

  mul_add_shift #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // One start pulse from IDLE; checks latency, busy width, product, single-cycle done and hold.
  task automatic do_mul(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                        input logic [7:0] exp_r, input int exp_lat, input int exp_busy);
    int lat;
    int busy_n;
    @(negedge clk);
    mif.start = 1'b1;
    mif.a     = ta;
    mif.b     = tb;
    @(negedge clk);
    mif.start = 1'b0;
    lat    = 0;
    busy_n = 0;
    for (int i = 0; i < 20; i++) begin
      if (mif.busy) busy_n++;
      if (mif.done) break;
      lat++;
      @(negedge clk);
    end
    check({tag, "_lat"},  lat,      exp_lat);
    check({tag, "_busy"}, busy_n,   exp_busy);
    check({tag, "_rslt"}, mif.rslt, exp_r);
    @(negedge clk);
    check({tag, "_done_pulse"}, {mif.done, mif.busy}, 2'b00);
    @(negedge clk);
    check({tag, "_hold"}, mif.rslt, exp_r);
  endtask

  initial begin
    int ndone;
    logic [7:0] seen_r;
    int t_done [3];

    mif.start = 1'b0;
    mif.a     = '0;
    mif.b     = '0;

    // Reset state
    @(negedge clk);
    check("rst_busy", mif.busy, 1'b0);
    check("rst_done", mif.done, 1'b0);
    check("rst_rslt", mif.rslt, 8'h00);
    rst = 1'b0;

    // Basic products, carry path and trivial case
    do_mul("m13x11", 4'd13, 4'd11, 8'h8F, N, N + 1);
    do_mul("m15x15", 4'd15, 4'd15, 8'hE1, N, N + 1);
    do_mul("m1x1",   4'd1,  4'd1,  8'h01, N, N + 1);

    // Zero operand: latency depends on the skip option
    do_mul("m0x9", 4'd0, 4'd9, 8'h00, ZERO_LAT, ZERO_BUSY);

    // Start re-pulsed during RUN must be ignored
    @(negedge clk);
    mif.start = 1'b1;
    mif.a     = 4'd7;
    mif.b     = 4'd6;
    @(negedge clk);
    mif.start = 1'b0;
    @(negedge clk);
    mif.start = 1'b1;
    mif.a     = 4'd3;
    mif.b     = 4'd3;
    @(negedge clk);
    mif.start = 1'b0;
    ndone  = 0;
    seen_r = '0;
    for (int i = 0; i < 12; i++) begin
      if (mif.done) begin
        ndone++;
        seen_r = mif.rslt;
      end
      @(negedge clk);
    end
    check("ignore_ndone", ndone, 1);
    check("ignore_rslt",  seen_r, 8'h2A);
    check("ignore_idle",  mif.busy, 1'b0);

    // Asynchronous reset two cycles into RUN
    mif.start = 1'b1;
    mif.a     = 4'd9;
    mif.b     = 4'd9;
    @(negedge clk);
    mif.start = 1'b0;
    @(negedge clk);
    check("abort_busy_before", mif.busy, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", mif.busy, 1'b0);
    check("abort_done", mif.done, 1'b0);
    check("abort_rslt", mif.rslt, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    do_mul("m5x5", 4'd5, 4'd5, 8'h19, N, N + 1);

    // Start held high: back-to-back operations spaced N+2 cycles
    @(negedge clk);
    mif.start = 1'b1;
    mif.a     = 4'd2;
    mif.b     = 4'd7;
    ndone = 0;
    for (int c = 1; c <= 30 && ndone < 3; c++) begin
      @(negedge clk);
      if (mif.done) begin
        t_done[ndone] = c;
        check($sformatf("held_rslt%0d", ndone), mif.rslt, 8'h0E);
        ndone++;
      end
    end
    mif.start = 1'b0;
    check("held_ndone", ndone, 3);
    if (ndone == 3) begin
      check("held_space1", t_done[1] - t_done[0], N + 2);
      check("held_space2", t_done[2] - t_done[1], N + 2);
    end
    for (int i = 0; i < 20; i++) begin
      if (!mif.busy && !mif.done) break;
      @(negedge clk);
    end
    check("held_drain", {mif.busy, mif.done}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
